// File: rtl/enemy_fire_scheduler_pkg.sv
// Shared types and default timing constants for the enemy fire scheduler.
package enemy_fire_scheduler_pkg;

    typedef enum logic [1:0] {
        SCH_IDLE     = 2'd0,
        SCH_BURST    = 2'd1,
        SCH_COOLDOWN = 2'd2
    } sched_state_t;

    localparam int unsigned DEF_NUM_SLOTS   = 4;
    localparam int unsigned DEF_BURST_LEN   = 3;
    localparam int unsigned DEF_BURST_GAP   = 8;
    localparam int unsigned DEF_COOLDOWN_TK = 30;

    localparam int unsigned TICK_W = 8;
    localparam int unsigned SHOT_W = 4;
    localparam int unsigned HIT_W  = 8;

endpackage

// File: rtl/rr_free_picker.sv
// Combinational round-robin picker: first set bit of free at or after ptr, wrapping.
module rr_free_picker #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] free,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 found_c,
    output logic [NUM_SLOTS-1:0] grant_c,
    output logic [IDX_W-1:0]     index_c
);

    logic [IDX_W-1:0] k;

    always_comb begin
        found_c = 1'b0;
        grant_c = '0;
        index_c = '0;
        k       = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            k = IDX_W'((32'(ptr) + i) % NUM_SLOTS);
            if (!found_c && free[k]) begin
                found_c    = 1'b1;
                grant_c[k] = 1'b1;
                index_c    = k;
            end
        end
    end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Turns AI attack requests into tick-timed bursts spread round-robin over a bullet pool,
// and aggregates the per-bullet hit flags.
module enemy_fire_scheduler
    import enemy_fire_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = DEF_NUM_SLOTS,
    parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
    parameter int unsigned BURST_GAP   = DEF_BURST_GAP,
    parameter int unsigned COOLDOWN_TK = DEF_COOLDOWN_TK
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 tick,
    input  logic                 attack_req,
    input  logic                 defend,
    input  logic [NUM_SLOTS-1:0] slot_active,
    input  logic [NUM_SLOTS-1:0] slot_hit,
    output logic [NUM_SLOTS-1:0] fire,
    output logic                 busy,
    output logic                 hit_pulse,
    output logic [HIT_W-1:0]     hit_count
);

    localparam int unsigned IDX_W = $clog2(NUM_SLOTS);
    localparam int unsigned SUM_W = HIT_W + 1;
    localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(BURST_GAP - 1);
    localparam logic [TICK_W-1:0] COOL_LAST = TICK_W'(COOLDOWN_TK - 1);
    localparam logic [SHOT_W-1:0] SHOT_LAST = SHOT_W'(BURST_LEN);

    sched_state_t          state, state_next;
    logic [TICK_W-1:0]     tick_cnt, tick_cnt_next;
    logic [SHOT_W-1:0]     shot_cnt, shot_cnt_next;
    logic [IDX_W-1:0]      rr_ptr, rr_ptr_next;
    logic [NUM_SLOTS-1:0]  pending, pending_next;
    logic [NUM_SLOTS-1:0]  pend_age, pend_age_next;
    logic [NUM_SLOTS-1:0]  active_q;
    logic [NUM_SLOTS-1:0]  fire_next;
    logic [HIT_W-1:0]      hit_count_next;
    logic [SUM_W-1:0]      hit_sum_c;
    logic                  issue_c;
    logic                  found_c;
    logic [NUM_SLOTS-1:0]  grant_c;
    logic [IDX_W-1:0]      index_c;

    rr_free_picker #(
        .NUM_SLOTS(NUM_SLOTS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .free   (~slot_active & ~pending),
        .ptr    (rr_ptr),
        .found_c(found_c),
        .grant_c(grant_c),
        .index_c(index_c)
    );

    // Next-state: the FSM only moves on game ticks; en=0 forces IDLE regardless.
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        shot_cnt_next = shot_cnt;
        issue_c       = 1'b0;
        if (!en) begin
            state_next    = SCH_IDLE;
            tick_cnt_next = '0;
            shot_cnt_next = '0;
        end else if (tick) begin
            case (state)
                SCH_IDLE: begin
                    if (attack_req && !defend) begin
                        issue_c       = 1'b1;
                        shot_cnt_next = SHOT_W'(1);
                        tick_cnt_next = '0;
                        state_next    = (BURST_LEN == 1) ? SCH_COOLDOWN : SCH_BURST;
                    end
                end
                SCH_BURST: begin
                    if (defend) begin
                        state_next    = SCH_COOLDOWN;
                        tick_cnt_next = '0;
                    end else if (tick_cnt == GAP_LAST) begin
                        issue_c       = 1'b1;
                        tick_cnt_next = '0;
                        shot_cnt_next = shot_cnt + SHOT_W'(1);
                        if (shot_cnt + SHOT_W'(1) == SHOT_LAST) state_next = SCH_COOLDOWN;
                    end else begin
                        tick_cnt_next = tick_cnt + TICK_W'(1);
                    end
                end
                SCH_COOLDOWN: begin
                    if (tick_cnt == COOL_LAST) begin
                        state_next    = SCH_IDLE;
                        tick_cnt_next = '0;
                    end else begin
                        tick_cnt_next = tick_cnt + TICK_W'(1);
                    end
                end
                default: begin
                    state_next    = SCH_IDLE;
                    tick_cnt_next = '0;
                    shot_cnt_next = '0;
                end
            endcase
        end
    end

    // Shot dispatch, pending mask (covers the bullet's 1-cycle isE latency) and hit aggregation.
    always_comb begin
        fire_next     = (issue_c && found_c) ? grant_c : '0;
        rr_ptr_next   = rr_ptr;
        pending_next  = pending;
        pend_age_next = pend_age;
        hit_sum_c     = {1'b0, hit_count};
        if (issue_c && found_c) begin
            rr_ptr_next = (index_c == IDX_W'(NUM_SLOTS - 1)) ? '0 : index_c + IDX_W'(1);
        end
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (fire_next[k]) begin
                pending_next[k]  = 1'b1;
                pend_age_next[k] = 1'b0;
            end else if (pending[k]) begin
                if ((slot_active[k] && !active_q[k]) || pend_age[k]) begin
                    pending_next[k]  = 1'b0;
                    pend_age_next[k] = 1'b0;
                end else begin
                    pend_age_next[k] = 1'b1;
                end
            end
            hit_sum_c = hit_sum_c + SUM_W'(slot_hit[k]);
        end
        hit_count_next = hit_sum_c[HIT_W] ? '1 : hit_sum_c[HIT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCH_IDLE;
            tick_cnt  <= '0;
            shot_cnt  <= '0;
            rr_ptr    <= '0;
            pending   <= '0;
            pend_age  <= '0;
            active_q  <= '0;
            fire      <= '0;
            busy      <= 1'b0;
            hit_pulse <= 1'b0;
            hit_count <= '0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_cnt_next;
            shot_cnt  <= shot_cnt_next;
            rr_ptr    <= rr_ptr_next;
            pending   <= pending_next;
            pend_age  <= pend_age_next;
            active_q  <= slot_active;
            fire      <= fire_next;
            busy      <= (state_next != SCH_IDLE);
            hit_pulse <= |slot_hit;
            hit_count <= hit_count_next;
        end
    end

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Self-checking bench for enemy_fire_scheduler with default parameters.
module tb_enemy_fire_scheduler;

    logic       clk = 1'b0;
    logic       rst, en, tick, attack_req, defend;
    logic [3:0] slot_active, slot_hit;
    logic [3:0] fire;
    logic       busy, hit_pulse;
    logic [7:0] hit_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] fire_q[$];
    logic       busy_q[$];
    logic [7:0] cnt_q[$];

    enemy_fire_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tick       (tick),
        .attack_req (attack_req),
        .defend     (defend),
        .slot_active(slot_active),
        .slot_hit   (slot_hit),
        .fire       (fire),
        .busy       (busy),
        .hit_pulse  (hit_pulse),
        .hit_count  (hit_count)
    );

    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_clk();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; tick = 1'b0; attack_req = 1'b0; defend = 1'b0;
        slot_active = 4'b0000; slot_hit = 4'b0000;
        clk1();
        clk1();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (fire !== 4'b0000) begin n_err++; $display("FAIL reset_fire got %b want 0000", fire); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (hit_pulse !== 1'b0) begin n_err++; $display("FAIL reset_hit_pulse got %b want 0", hit_pulse); end
        n_cmp++; if (hit_count !== 8'd0) begin n_err++; $display("FAIL reset_hit_count got %0d want 0", hit_count); end
    endtask

    // Three shots 8 ticks apart, 30-tick cooldown, then next burst on slot 3.
    task automatic test_burst_default();
        logic [3:0] ef;
        logic       eb;
        do_reset();
        attack_req = 1'b1;
        for (int j = 0; j < 48; j++) begin
            ef = (j == 0) ? 4'b0001 : (j == 8) ? 4'b0010 : (j == 16) ? 4'b0100 :
                 (j == 47) ? 4'b1000 : 4'b0000;
            fire_q.push_back(ef);
            busy_q.push_back(j != 46);
            tick_clk();
            ef = fire_q.pop_front();
            eb = busy_q.pop_front();
            n_cmp++; if (fire !== ef) begin n_err++; $display("FAIL burst_fire tick %0d got %b want %b", j, fire, ef); end
            n_cmp++; if (busy !== eb) begin n_err++; $display("FAIL burst_busy tick %0d got %b want %b", j, busy, eb); end
            clk1();
            n_cmp++; if (fire !== 4'b0000) begin n_err++; $display("FAIL burst_fire_width tick %0d got %b want 0000", j, fire); end
            clk1();
            clk1();
        end
        attack_req = 1'b0;
    endtask

    // All slots occupied: every shot dropped but schedule unchanged.
    task automatic test_all_busy();
        logic [3:0] ef;
        logic       eb;
        do_reset();
        slot_active = 4'b1111;
        attack_req  = 1'b1;
        for (int j = 0; j < 47; j++) begin
            fire_q.push_back(4'b0000);
            busy_q.push_back(j != 46);
            tick_clk();
            ef = fire_q.pop_front();
            eb = busy_q.pop_front();
            n_cmp++; if (fire !== ef) begin n_err++; $display("FAIL allbusy_fire tick %0d got %b want %b", j, fire, ef); end
            n_cmp++; if (busy !== eb) begin n_err++; $display("FAIL allbusy_busy tick %0d got %b want %b", j, busy, eb); end
            clk1();
        end
        attack_req  = 1'b0;
        slot_active = 4'b0000;
    endtask

    // Defend on the tick after the first shot aborts straight into cooldown.
    task automatic test_defend();
        logic [3:0] ef;
        logic       eb;
        do_reset();
        attack_req = 1'b1;
        for (int j = 0; j < 33; j++) begin
            defend = (j == 1);
            fire_q.push_back((j == 0) ? 4'b0001 : (j == 32) ? 4'b0010 : 4'b0000);
            busy_q.push_back(j != 31);
            tick_clk();
            defend = 1'b0;
            ef = fire_q.pop_front();
            eb = busy_q.pop_front();
            n_cmp++; if (fire !== ef) begin n_err++; $display("FAIL defend_fire tick %0d got %b want %b", j, fire, ef); end
            n_cmp++; if (busy !== eb) begin n_err++; $display("FAIL defend_busy tick %0d got %b want %b", j, busy, eb); end
            clk1();
        end
        attack_req = 1'b0;
    endtask

    task automatic test_hits();
        logic [7:0] exp_cnt;
        logic [8:0] sum;
        logic [3:0] pat;
        logic [7:0] ec;
        do_reset();
        exp_cnt  = 8'd0;
        slot_hit = 4'b0101;
        cnt_q.push_back(8'd2);
        clk1();
        slot_hit = 4'b0000;
        ec = cnt_q.pop_front();
        n_cmp++; if (hit_pulse !== 1'b1) begin n_err++; $display("FAIL hit_pulse_on got %b want 1", hit_pulse); end
        n_cmp++; if (hit_count !== ec) begin n_err++; $display("FAIL hit_count_two got %0d want %0d", hit_count, ec); end
        exp_cnt = ec;
        clk1();
        n_cmp++; if (hit_pulse !== 1'b0) begin n_err++; $display("FAIL hit_pulse_off got %b want 0", hit_pulse); end
        for (int j = 0; j < 66; j++) begin
            pat = (j < 62) ? 4'b1111 : (j == 62) ? 4'b0011 : (j == 63) ? 4'b0101 : 4'b1111;
            sum = {1'b0, exp_cnt} + 9'($countones(pat));
            exp_cnt = (sum > 9'd255) ? 8'd255 : sum[7:0];
            cnt_q.push_back(exp_cnt);
            slot_hit = pat;
            clk1();
            slot_hit = 4'b0000;
            ec = cnt_q.pop_front();
            n_cmp++; if (hit_count !== ec) begin n_err++; $display("FAIL hit_count step %0d got %0d want %0d", j, hit_count, ec); end
        end
        clk1();
        n_cmp++; if (hit_count !== 8'd255) begin n_err++; $display("FAIL hit_count_sat got %0d want 255", hit_count); end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        slot_hit = 4'b0001;
        clk1();
        slot_hit   = 4'b0000;
        attack_req = 1'b1;
        tick_clk();
        n_cmp++; if (fire !== 4'b0001) begin n_err++; $display("FAIL rstmid_fire_before got %b want 0001", fire); end
        rst = 1'b1;
        clk1();
        n_cmp++; if (fire !== 4'b0000) begin n_err++; $display("FAIL rstmid_fire got %b want 0000", fire); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_cmp++; if (hit_pulse !== 1'b0) begin n_err++; $display("FAIL rstmid_hit_pulse got %b want 0", hit_pulse); end
        n_cmp++; if (hit_count !== 8'd0) begin n_err++; $display("FAIL rstmid_hit_count got %0d want 0", hit_count); end
        tick = 1'b1;
        clk1();
        tick = 1'b0;
        n_cmp++; if (fire !== 4'b0000) begin n_err++; $display("FAIL rstmid_decide_fire got %b want 0000", fire); end
        rst = 1'b0;
        tick_clk();
        n_cmp++; if (fire !== 4'b0001) begin n_err++; $display("FAIL rstmid_rr_ptr got %b want 0001", fire); end
        attack_req = 1'b0;
    endtask

    task automatic test_en_drop();
        do_reset();
        attack_req = 1'b1;
        tick_clk();
        n_cmp++; if (fire !== 4'b0001) begin n_err++; $display("FAIL en_first_fire got %b want 0001", fire); end
        repeat (3) tick_clk();
        en = 1'b0;
        tick_clk();
        n_cmp++; if (fire !== 4'b0000) begin n_err++; $display("FAIL en_off_fire got %b want 0000", fire); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL en_off_busy got %b want 0", busy); end
        tick_clk();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL en_off_busy2 got %b want 0", busy); end
        en = 1'b1;
        tick_clk();
        n_cmp++; if (fire !== 4'b0010) begin n_err++; $display("FAIL en_restore_fire got %b want 0010", fire); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL en_restore_busy got %b want 1", busy); end
        attack_req = 1'b0;
    endtask

    // Occupied slots are skipped and the search wraps past the top slot.
    task automatic test_rr_skip();
        logic [3:0] ef;
        do_reset();
        slot_active = 4'b0011;
        attack_req  = 1'b1;
        tick_clk();
        n_cmp++; if (fire !== 4'b0100) begin n_err++; $display("FAIL skip_first got %b want 0100", fire); end
        slot_active = 4'b1000;
        for (int j = 1; j <= 8; j++) begin
            fire_q.push_back((j == 8) ? 4'b0001 : 4'b0000);
            tick_clk();
            ef = fire_q.pop_front();
            n_cmp++; if (fire !== ef) begin n_err++; $display("FAIL skip_wrap tick %0d got %b want %b", j, fire, ef); end
        end
        attack_req  = 1'b0;
        slot_active = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_burst_default();
        test_all_busy();
        test_defend();
        test_hits();
        test_reset_midburst();
        test_en_drop();
        test_rr_skip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
